// File: rtl/rom_arb_ctrl.sv
// rom_arb_ctrl: arbitrates two byte-read requesters (A = CPU, B = ROM-to-DRAM
// copier) onto a shared ROM built from two 8K halves. Each access is a fixed
// sequence IDLE -> ISSUE -> WAIT (ROM_LAT cycles) -> CAPTURE -> IDLE.
//
// Configuration macro: ROM_ARB_RR_EN
//   defined   -> round-robin between A and B on simultaneous requests
//   undefined -> fixed priority, A wins ties (default build)
//
// Parameter:
//   ROM_LAT   ROM read latency in clk cycles (legal 1..4)
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   a_req/a_addr         requester A request + 14-bit byte address
//   a_ack                one-cycle grant acknowledge to A
//   a_rdata/a_valid      read byte for A, valid for one cycle
//   b_*                  same set for requester B
//   rom_ad               13-bit address into the selected ROM half
//   rom0_ce/rom1_ce      chip enables of the low/high 8K halves
//   rom_oce              ROM output enable
//   rom_dout             shared ROM data bus
//   busy                 high whenever the FSM is not IDLE
//
// All outputs except busy are registered: a value decided in a given state
// becomes visible on the following cycle. So with a request seen in cycle T,
// ack appears in T+1 (state ISSUE), ce in T+2..T+4, oce in T+3..T+4 and
// valid in T+ROM_LAT+3.
module rom_arb_ctrl #(
    parameter int ROM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic [13:0] a_addr,
    output logic        a_ack,
    output logic [7:0]  a_rdata,
    output logic        a_valid,
    input  logic        b_req,
    input  logic [13:0] b_addr,
    output logic        b_ack,
    output logic [7:0]  b_rdata,
    output logic        b_valid,
    output logic [12:0] rom_ad,
    output logic        rom0_ce,
    output logic        rom1_ce,
    output logic        rom_oce,
    input  logic [7:0]  rom_dout,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    // WAIT lasts ROM_LAT cycles: the counter is loaded with ROM_LAT-1 and the
    // FSM leaves WAIT in the cycle it reads zero.
    localparam logic [2:0] CNT_LOAD = 3'(ROM_LAT - 1);

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic        gnt_b_q;
    logic [13:0] addr_q;
    logic        a_ack_q, b_ack_q;
    logic        a_valid_q, b_valid_q;
    logic [7:0]  a_rdata_q, b_rdata_q;
    logic [12:0] rom_ad_q;
    logic        rom0_ce_q, rom1_ce_q, rom_oce_q;
    logic        pick_b;

`ifdef ROM_ARB_RR_EN
    // 1 when B received the most recent grant.
    logic        last_b_q;

    // On a tie, grant whoever did not win last time.
    assign pick_b = b_req && (!a_req || !last_b_q);
`else
    // Fixed priority: B only wins when A is not asking.
    assign pick_b = b_req && !a_req;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 3'd0;
            gnt_b_q   <= 1'b0;
            addr_q    <= 14'd0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            a_rdata_q <= 8'd0;
            b_rdata_q <= 8'd0;
            rom_ad_q  <= 13'd0;
            rom0_ce_q <= 1'b0;
            rom1_ce_q <= 1'b0;
            rom_oce_q <= 1'b0;
`ifdef ROM_ARB_RR_EN
            last_b_q  <= 1'b1;
`endif
        end else begin
            // ack and valid are single-cycle pulses.
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (a_req || b_req) begin
                        // Address is latched here so later requester changes
                        // cannot disturb the access in flight.
                        gnt_b_q <= pick_b;
                        addr_q  <= pick_b ? b_addr : a_addr;
                        if (pick_b) begin
                            b_ack_q <= 1'b1;
                        end else begin
                            a_ack_q <= 1'b1;
                        end
`ifdef ROM_ARB_RR_EN
                        last_b_q <= pick_b;
`endif
                        state_q <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    // rom_ad only changes here, so it holds between accesses.
                    rom_ad_q  <= addr_q[12:0];
                    rom1_ce_q <= addr_q[13];
                    rom0_ce_q <= ~addr_q[13];
                    rom_oce_q <= 1'b0;
                    cnt_q     <= CNT_LOAD;
                    state_q   <= S_WAIT;
                end

                S_WAIT: begin
                    rom_oce_q <= 1'b1;
                    if (cnt_q == 3'd0) begin
                        state_q <= S_CAPTURE;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end

                S_CAPTURE: begin
                    // ROM data is valid now; only the granted side updates.
                    if (gnt_b_q) begin
                        b_rdata_q <= rom_dout;
                        b_valid_q <= 1'b1;
                    end else begin
                        a_rdata_q <= rom_dout;
                        a_valid_q <= 1'b1;
                    end
                    rom0_ce_q <= 1'b0;
                    rom1_ce_q <= 1'b0;
                    rom_oce_q <= 1'b0;
                    state_q   <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign a_ack   = a_ack_q;
    assign b_ack   = b_ack_q;
    assign a_valid = a_valid_q;
    assign b_valid = b_valid_q;
    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;
    assign rom_ad  = rom_ad_q;
    assign rom0_ce = rom0_ce_q;
    assign rom1_ce = rom1_ce_q;
    assign rom_oce = rom_oce_q;
    assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_rom_arb_ctrl.sv
module tb_rom_arb_ctrl;

    localparam int ROM_LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, b_req;
    logic [13:0] a_addr, b_addr;
    logic        a_ack, a_valid, b_ack, b_valid;
    logic [7:0]  a_rdata, b_rdata;
    logic [12:0] rom_ad;
    logic        rom0_ce, rom1_ce, rom_oce;
    logic [7:0]  rom_dout;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rom_arb_ctrl #(.ROM_LAT(ROM_LAT)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_rdata(a_rdata), .a_valid(a_valid),
        .b_req(b_req), .b_addr(b_addr), .b_ack(b_ack), .b_rdata(b_rdata), .b_valid(b_valid),
        .rom_ad(rom_ad), .rom0_ce(rom0_ce), .rom1_ce(rom1_ce), .rom_oce(rom_oce),
        .rom_dout(rom_dout), .busy(busy)
    );

    // ROM contents: ROM0[i] = i[7:0]^AA (ROM0[5]=AF), ROM1[i] = i[7:0]+3C (ROM1[16]=4C).
    function automatic logic [7:0] r0(input logic [12:0] a);
        return a[7:0] ^ 8'hAA;
    endfunction
    function automatic logic [7:0] r1(input logic [12:0] a);
        return a[7:0] + 8'h3C;
    endfunction

    // ROM model: address sampled on an edge with ce high, data out ROM_LAT cycles later.
    logic [7:0] pipe [ROM_LAT];
    always @(posedge clk) begin
        if (rom0_ce || rom1_ce) pipe[0] <= rom1_ce ? r1(rom_ad) : r0(rom_ad);
        for (int i = 1; i < ROM_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign rom_dout = pipe[ROM_LAT-1];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_cmp++;
        if ({a_ack, a_valid, b_ack, b_valid, rom0_ce, rom1_ce, rom_oce, busy} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 00000000",
                     {a_ack, a_valid, b_ack, b_valid, rom0_ce, rom1_ce, rom_oce, busy});
        end
        n_cmp++;
        if ({a_rdata, b_rdata, rom_ad} !== 29'd0) begin
            n_bad++;
            $display("FAIL reset_data: got a_rdata=%h b_rdata=%h rom_ad=%h want 0", a_rdata, b_rdata, rom_ad);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_read();
        a_addr = 14'h0005; a_req = 1'b1;                 // cycle T
        n_cmp++;
        if (a_ack !== 1'b0) begin n_bad++; $display("FAIL single_ack_T: got %b want 0", a_ack); end
        step();                                          // T+1
        n_cmp++;
        if ({a_ack, busy} !== 2'b11) begin n_bad++; $display("FAIL single_ack_T1: got ack,busy=%b want 11", {a_ack, busy}); end
        a_req = 1'b0;
        step();                                          // T+2
        n_cmp++;
        if ({rom0_ce, rom1_ce, rom_oce, a_ack} !== 4'b1000 || rom_ad !== 13'h0005) begin
            n_bad++; $display("FAIL single_issue: got ce0,ce1,oce,ack=%b ad=%h want 1000 0005", {rom0_ce, rom1_ce, rom_oce, a_ack}, rom_ad);
        end
        step();                                          // T+3
        n_cmp++;
        if ({rom0_ce, rom1_ce, rom_oce} !== 3'b101) begin n_bad++; $display("FAIL single_wait1: got %b want 101", {rom0_ce, rom1_ce, rom_oce}); end
        step();                                          // T+4
        n_cmp++;
        if ({rom0_ce, rom1_ce, rom_oce, a_valid} !== 4'b1010) begin n_bad++; $display("FAIL single_wait2: got %b want 1010", {rom0_ce, rom1_ce, rom_oce, a_valid}); end
        step();                                          // T+5
        n_cmp++;
        if ({a_valid, rom0_ce, rom1_ce, rom_oce, busy} !== 5'b10000 || a_rdata !== 8'hAF) begin
            n_bad++; $display("FAIL single_capture: got flags=%b rdata=%h want 10000 AF", {a_valid, rom0_ce, rom1_ce, rom_oce, busy}, a_rdata);
        end
        step();                                          // T+6
        n_cmp++;
        if ({a_valid, b_valid} !== 2'b00 || a_rdata !== 8'hAF || b_rdata !== 8'h00) begin
            n_bad++; $display("FAIL single_hold: got valids=%b a=%h b=%h want 00 AF 00", {a_valid, b_valid}, a_rdata, b_rdata);
        end
    endtask

    task automatic test_half_select();
        b_addr = 14'h2010; b_req = 1'b1;                 // T
        step();                                          // T+1
        n_cmp++;
        if ({b_ack, a_ack} !== 2'b10) begin n_bad++; $display("FAIL half_ack: got b,a=%b want 10", {b_ack, a_ack}); end
        b_req = 1'b0;
        step();                                          // T+2
        n_cmp++;
        if ({rom0_ce, rom1_ce, rom_oce} !== 3'b010 || rom_ad !== 13'h0010) begin
            n_bad++; $display("FAIL half_issue: got ce0,ce1,oce=%b ad=%h want 010 0010", {rom0_ce, rom1_ce, rom_oce}, rom_ad);
        end
        step(); step(); step();                          // T+5
        n_cmp++;
        if ({b_valid, a_valid} !== 2'b10 || b_rdata !== 8'h4C || a_rdata !== 8'hAF) begin
            n_bad++; $display("FAIL half_capture: got valids=%b b=%h a=%h want 10 4C AF", {b_valid, a_valid}, b_rdata, a_rdata);
        end
        step();                                          // T+6
        n_cmp++;
        if (b_valid !== 1'b0 || rom_ad !== 13'h0010 || b_rdata !== 8'h4C) begin
            n_bad++; $display("FAIL half_hold: got valid=%b ad=%h b=%h want 0 0010 4C", b_valid, rom_ad, b_rdata);
        end
    endtask

    task automatic test_back_to_back_tie();
        logic       gnt_b [4];
        int         ack_c [4];
        logic [3:0] got_pat, exp_pat;
        int         k = 0;
        a_addr = 14'h0001; b_addr = 14'h2002;
        a_req = 1'b1; b_req = 1'b1;                      // T
        for (int c = 1; c <= 20; c++) begin
            step();
            if (a_ack && b_ack) begin
                n_cmp++; n_bad++;
                $display("FAIL tie_double_ack: both acks high at T+%0d", c);
            end
            if (a_ack || b_ack) begin
                if (k < 4) begin gnt_b[k] = b_ack; ack_c[k] = c; end
                k++;
            end
        end
        // Now at T+20: the fourth transaction's valid is visible.
`ifdef ROM_ARB_RR_EN
        exp_pat = 4'b1010;
        n_cmp++;
        if (b_valid !== 1'b1 || b_rdata !== 8'h3E) begin n_bad++; $display("FAIL tie_last_data: got b_valid=%b b_rdata=%h want 1 3E", b_valid, b_rdata); end
`else
        exp_pat = 4'b0000;
        n_cmp++;
        if (a_valid !== 1'b1 || a_rdata !== 8'hAB) begin n_bad++; $display("FAIL tie_last_data: got a_valid=%b a_rdata=%h want 1 AB", a_valid, a_rdata); end
`endif
        a_req = 1'b0; b_req = 1'b0;
        n_cmp++;
        if (k !== 4) begin n_bad++; $display("FAIL tie_count: got %0d acks want 4", k); end
        if (k >= 4) begin
            got_pat = {gnt_b[3], gnt_b[2], gnt_b[1], gnt_b[0]};
            n_cmp++;
            if (got_pat !== exp_pat) begin n_bad++; $display("FAIL tie_order: got b-grant pattern %b want %b", got_pat, exp_pat); end
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (ack_c[i] !== 1 + 5 * i) begin n_bad++; $display("FAIL tie_spacing%0d: got T+%0d want T+%0d", i, ack_c[i], 1 + 5 * i); end
            end
        end
        step();
        n_cmp++;
        if ({busy, a_ack, b_ack} !== 3'b000) begin n_bad++; $display("FAIL tie_idle: got busy,a_ack,b_ack=%b want 000", {busy, a_ack, b_ack}); end
    endtask

    task automatic test_reset_in_wait();
        logic seen;
        a_addr = 14'h0007; a_req = 1'b1;                 // T
        step(); a_req = 1'b0;                            // T+1
        step();                                          // T+2
        step(); reset = 1'b1;                            // T+3: FSM in WAIT
        step();                                          // T+4
        n_cmp++;
        if ({a_ack, a_valid, b_ack, b_valid, rom0_ce, rom1_ce, rom_oce, busy} !== 8'h00 ||
            {a_rdata, b_rdata, rom_ad} !== 29'd0) begin
            n_bad++; $display("FAIL rst_wait_outs: got flags=%b a=%h b=%h ad=%h want all 0",
                {a_ack, a_valid, b_ack, b_valid, rom0_ce, rom1_ce, rom_oce, busy}, a_rdata, b_rdata, rom_ad);
        end
        reset = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (a_valid || busy || rom0_ce) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin n_bad++; $display("FAIL rst_wait_abort: got activity=%b want 0", seen); end
        a_addr = 14'h0123; a_req = 1'b1;                 // new T
        step();
        n_cmp++;
        if (a_ack !== 1'b1) begin n_bad++; $display("FAIL rst_wait_reack: got %b want 1", a_ack); end
        a_req = 1'b0;
        step(); step(); step(); step();                  // T+5
        n_cmp++;
        if (a_valid !== 1'b1 || a_rdata !== 8'h89) begin n_bad++; $display("FAIL rst_wait_read: got valid=%b rdata=%h want 1 89", a_valid, a_rdata); end
        step();
    endtask

    task automatic test_short_pulse();
        logic seen_b;
        a_addr = 14'h0009; a_req = 1'b1;                 // T
        step(); a_req = 1'b0;                            // T+1
        step();                                          // T+2 (busy)
        b_addr = 14'h2033; b_req = 1'b1;
        step(); b_req = 1'b0;                            // T+3
        seen_b = 1'b0;
        for (int c = 3; c <= 10; c++) begin
            if (b_ack || b_valid || rom1_ce) seen_b = 1'b1;
            if (c == 5) begin
                n_cmp++;
                if (a_valid !== 1'b1 || a_rdata !== 8'hA3) begin n_bad++; $display("FAIL pulse_a_read: got valid=%b rdata=%h want 1 A3", a_valid, a_rdata); end
            end
            step();
        end
        n_cmp++;
        if (seen_b !== 1'b0) begin n_bad++; $display("FAIL pulse_b_ignored: got b activity=%b want 0", seen_b); end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL pulse_idle: got busy=%b want 0", busy); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; a_req = 1'b0; b_req = 1'b0; a_addr = '0; b_addr = '0;
        #1;
        test_reset();
        test_single_read();
        test_half_select();
        test_back_to_back_tie();
        test_reset_in_wait();
        test_short_pulse();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rom_arb_ctrl.md
ROM_ARB_CTRL -- requirements
Module: rom_arb_ctrl

Interface
REQ-001 SHALL have parameter: ROM_LAT, 2, ROM read latency in clk cycles from ce/ad registered to data valid on rom_dout (legal 1..4).
REQ-002 SHALL have port: clk  in  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: a_req  in  1, a_addr  in  14, a_ack  out  1, a_rdata  out  8, a_valid  out  1; requester A (CPU).
REQ-005 SHALL have ports: b_req  in  1, b_addr  in  14, b_ack  out  1, b_rdata  out  8, b_valid  out  1; requester B (ROM-to-DRAM copier).
REQ-006 SHALL have ports: rom_ad  out  13, rom0_ce  out  1, rom1_ce  out  1, rom_oce  out  1, rom_dout  in  8 (shared 8K ROM halves' data bus).
REQ-007 SHALL have port: busy  out  1  high whenever state is not IDLE.

Function
REQ-008 SHALL implement FSM IDLE -> ISSUE -> WAIT -> CAPTURE -> IDLE.
REQ-009 IDLE: SHALL sample a_req/b_req every cycle; on any req, grant one requester, register its addr, pulse its ack for exactly one cycle (the cycle after the req is seen), go to ISSUE.
REQ-010 ISSUE (1 cycle): rom_ad = granted addr[12:0]; rom1_ce = addr[13], rom0_ce = ~addr[13]; rom_oce = 0.
REQ-011 WAIT (ROM_LAT cycles, down-counter): ce unchanged, rom_oce = 1; rom_dout sampled at the edge ending the last WAIT cycle.
REQ-012 CAPTURE (1 cycle): granted rdata = sampled byte, granted valid = 1 for exactly this cycle; ce and oce = 0; next state IDLE.
REQ-013 Latency: req first high in cycle T while IDLE -> ack in T+1 -> valid in T+ROM_LAT+3 (T+5 at default); one transaction per ROM_LAT+3 cycles max.
REQ-014 Exactly one of rom0_ce/rom1_ce SHALL be high in ISSUE/WAIT; both low in IDLE and CAPTURE; rom_oce high only in WAIT.
REQ-015 rdata of each requester SHALL hold its last captured value until its next valid; the non-granted requester's outputs SHALL not change.
REQ-016 Requesters hold req and addr until ack; req deasserted before grant SHALL produce no transaction; req/addr changes after ack SHALL not affect the transaction in flight.
REQ-017 Req held high after ack SHALL be treated as a new request once IDLE is re-entered.
REQ-018 Simultaneous a_req and b_req SHALL be resolved per REQ-022; the loser keeps waiting without ack.
REQ-019 rom_ad SHALL hold its last value outside ISSUE/WAIT (no toggling).

Reset
REQ-020 Reset SHALL force state IDLE, WAIT counter 0, ack/valid/ce/oce/busy 0, rom_ad 0, rdata 0, round-robin pointer to "B last granted".
REQ-021 Reset asserted mid-transaction SHALL abort it: no valid pulse for the aborted access, first post-reset grant no earlier than the cycle after reset deasserts.

Configuration
REQ-022 Macro ROM_ARB_RR_EN: defined -> round-robin, simultaneous requests go to the requester not granted last (pointer updates on every grant); undefined -> fixed priority, A always wins ties, pointer logic absent.

Verification
REQ-023 Single read: a_req, a_addr=14'h0005 at T (ROM0[5]=8'hAF) -> a_ack at T+1, rom0_ce high T+2..T+4, rom_oce high T+3..T+4, a_valid with a_rdata=8'hAF at T+5.
REQ-024 Half select: b_addr=14'h2010 -> rom1_ce high, rom0_ce low, rom_ad=13'h0010, b_rdata=ROM1[16].
REQ-025 Tie, macro undefined: a_req and b_req both high for 3 back-to-back transactions -> grants A,A,A; B never acked while A held.
REQ-026 Tie, ROM_ARB_RR_EN defined: both high continuously -> grants A,B,A,B; transactions every 5 cycles.
REQ-027 Reset in WAIT cycle: reset one cycle -> next cycle all outputs 0, no valid pulse; subsequent a_req completes normally with correct data.
REQ-028 Short pulse: b_req high one cycle while FSM busy -> no b_ack, no rom access for B.
